rename_ckpt_dispatch: RTL and testbench
=======================================

# rename_ckpt_dispatch

Parametrised N-wide rename/dispatch stage with internal map-table checkpoints. Sits between decode and the ROB/RS. It renames up to N instructions per cycle, including intra-group dependency forwarding, and gates dispatch on ROB, RS, free-list and checkpoint capacity. It owns the branch-mask state, snapshotting the map on each branch and restoring it locally on mispredict.

## Interface
Parameters:
- N, 2, dispatch width (lanes).
- ARCH_REGS, 32, architectural registers.
- PHYS_REGS, 64, physical registers.
- CKPTS, 4, checkpoint slots; equals branch-mask width.
- BR_PER_CYCLE, 1, max branches checkpointed per cycle (1..N).

Derived widths: AW=$clog2(ARCH_REGS), PW=$clog2(PHYS_REGS), CW=$clog2(CKPTS), SW=$clog2(N+1).

Ports:
- clock  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- in_count  in  SW  valid lanes; always a prefix starting at lane 0.
- in_src1, in_src2, in_dest  in  N×AW  architectural registers.
- in_rs1_used, in_rs2_used, in_has_dest, in_is_branch  in  N  per-lane flags.
- rob_spots, rs_spots  in  SW  free entries downstream.
- free_count  in  PW+1  regs available.
- free_regs  in  N×PW  next free pregs, in order.
- complete_list  in  PHYS_REGS  ready bits.
- cdb_valid  in  N  same-cycle completion broadcast valid.
- cdb_tag  in  N×PW  same-cycle completion broadcast tags.
- resolve_valid  in  1  branch resolve event.
- resolve_mispredict  in  1  resolve outcome.
- resolve_id  in  CW  resolved checkpoint slot.
- num_dispatched  out  SW  lanes accepted this cycle.
- num_regs_used  out  SW  free_regs consumed.
- out_src1, out_src2, out_dest, out_told  out  N×PW  renamed registers.
- out_src1_ready, out_src2_ready  out  N  operand ready flags.
- out_bmask  out  N×CKPTS  per-lane dependency mask.
- out_ckpt_valid  out  N  lane allocated a checkpoint.
- out_ckpt_id  out  N×CW  allocated slot.
- live_mask  out  CKPTS  registered live checkpoints.
- bmask_clear  out  CKPTS  one-hot broadcast on correct resolve.

## Operation
Renaming and dest lanes:
- A lane is a "dest lane" iff in_has_dest && in_dest!=0. Architectural register 0 never renames and is never marked busy.
- Dest lanes take free_regs in compacted order: the k-th dest lane gets free_regs[k].

Sources:
- Taken from the running map, meaning the registered map plus the renames of earlier lanes in the same group.
- Ready = !used || src maps to preg 0 || complete_list hit || cdb hit.
- A source produced by an earlier lane in the group is always not-ready.

T_old:
- Dest lane: the running-map value for in_dest.
- Non-dest lane: out_told = out_dest = 0.

num_dispatched is the largest k ≤ in_count satisfying all of:
- k ≤ rob_spots and k ≤ rs_spots;
- dest lanes in [0,k) ≤ free_count;
- every branch in [0,k) got a checkpoint.

Checkpoint allocation:
- Branches take the lowest free slots of ~live_mask, at most BR_PER_CYCLE per cycle.
- The first branch that cannot get a slot stops the group at that lane.

Branch masks:
- out_bmask[i] = live_mask & ~clear_now, OR the slots of earlier branches in the group.
- A branch lane's mask excludes its own slot.

Snapshot contents:
- The map after the branch's own rename.
- The parent mask, which equals out_bmask of that lane.

Resolve, correct: clear the bit in live_mask, in every stored parent mask and in the slot; drive bmask_clear one-hot for one cycle.

Resolve, mispredict:
- At the next edge, the map takes the slot's snapshot and live_mask takes the slot's parent mask; younger checkpoints are squashed.
- num_dispatched=0 that cycle.

Ignored resolves: a resolve to a non-live slot is ignored, with no clear and no restore.

Combinational outputs beyond num_dispatched are don't-care, except out_ckpt_valid, which is 0 there.

## Timing
- All outputs are combinational from the registered state plus inputs. Rename has zero latency.
- Map, live_mask and snapshots update at posedge.
- A slot freed by a correct resolve is allocatable only from the next cycle; allocation uses the registered live_mask.
- Simultaneous correct resolve and dispatch: the new lanes' out_bmask already exclude the cleared bit.

Reset:
- Map is the identity (arch i → preg i); live_mask=0; snapshots=0.
- During the reset cycle num_dispatched=0 and bmask_clear=0.
- Reset mid-operation discards all checkpoints.

## Structure
- Width macros (N, PHYS_REGS, CKPTS) and the checkpoint struct {map, parent_mask} go in sys_defs.svh.
- Slot selection uses psel_gen with REQS=BR_PER_CYCLE plus an encoder.
- No new sub-module is needed.

## Test plan
- Reset, then in_count=2 with src r1,r2, rob/rs=2, free_count=2 → num_dispatched=2, out_src1[0]=1, ready per complete_list.
- Lane0 dest r5→p40, lane1 src r5 → out_src1[1]=40, not ready; out_told[0]=5.
- free_count=1, two dest lanes → num_dispatched=1, num_regs_used=1.
- CKPTS=2 full, branch in lane1 → num_dispatched=1, out_ckpt_valid=0.
- Allocate slot0 then slot1 (child); mispredict slot0 → next cycle map restored, live_mask=0.
- Correct resolve slot0 with dispatch in the same cycle → bmask_clear=0001; new out_bmask bit0=0; slot0 is not reused until the following cycle.

Source files
------------

// File: rtl/rename_ckpt_dispatch_pkg.sv
// Shared definitions for the rename/dispatch stage: default geometry and the
// classification of a branch-resolve event.
package rename_ckpt_dispatch_pkg;

    localparam int DEF_N            = 2;
    localparam int DEF_ARCH_REGS    = 32;
    localparam int DEF_PHYS_REGS    = 64;
    localparam int DEF_CKPTS        = 4;
    localparam int DEF_BR_PER_CYCLE = 1;

    // What a resolve does this cycle once filtered against the live slots.
    typedef enum logic [1:0] {
        RES_NONE    = 2'd0,
        RES_CORRECT = 2'd1,
        RES_MISPRED = 2'd2
    } resolve_kind_e;

endpackage

// File: rtl/rename_ckpt_dispatch.sv
// N-wide rename/dispatch with map-table checkpoints.
// Renames a prefix of the incoming group (zero latency), forwarding
// destinations to younger lanes in the same group, and gates the group on
// ROB/RS space, free physical registers and free checkpoint slots. Each
// accepted branch snapshots the map (after its own rename) and its parent
// branch mask; a mispredict restores both at the next edge.
module rename_ckpt_dispatch
    import rename_ckpt_dispatch_pkg::*;
#(
    parameter int N            = DEF_N,
    parameter int ARCH_REGS    = DEF_ARCH_REGS,
    parameter int PHYS_REGS    = DEF_PHYS_REGS,
    parameter int CKPTS        = DEF_CKPTS,
    parameter int BR_PER_CYCLE = DEF_BR_PER_CYCLE,
    localparam int AW = $clog2(ARCH_REGS),
    localparam int PW = $clog2(PHYS_REGS),
    localparam int CW = $clog2(CKPTS),
    localparam int SW = $clog2(N + 1)
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [SW-1:0]                in_count,
    input  logic [N-1:0][AW-1:0]         in_src1,
    input  logic [N-1:0][AW-1:0]         in_src2,
    input  logic [N-1:0][AW-1:0]         in_dest,
    input  logic [N-1:0]                 in_rs1_used,
    input  logic [N-1:0]                 in_rs2_used,
    input  logic [N-1:0]                 in_has_dest,
    input  logic [N-1:0]                 in_is_branch,
    input  logic [SW-1:0]                rob_spots,
    input  logic [SW-1:0]                rs_spots,
    input  logic [PW:0]                  free_count,
    input  logic [N-1:0][PW-1:0]         free_regs,
    input  logic [PHYS_REGS-1:0]         complete_list,
    input  logic [N-1:0]                 cdb_valid,
    input  logic [N-1:0][PW-1:0]         cdb_tag,
    input  logic                         resolve_valid,
    input  logic                         resolve_mispredict,
    input  logic [CW-1:0]                resolve_id,
    output logic [SW-1:0]                num_dispatched,
    output logic [SW-1:0]                num_regs_used,
    output logic [N-1:0][PW-1:0]         out_src1,
    output logic [N-1:0][PW-1:0]         out_src2,
    output logic [N-1:0][PW-1:0]         out_dest,
    output logic [N-1:0][PW-1:0]         out_told,
    output logic [N-1:0]                 out_src1_ready,
    output logic [N-1:0]                 out_src2_ready,
    output logic [N-1:0][CKPTS-1:0]      out_bmask,
    output logic [N-1:0]                 out_ckpt_valid,
    output logic [N-1:0][CW-1:0]         out_ckpt_id,
    output logic [CKPTS-1:0]             live_mask,
    output logic [CKPTS-1:0]             bmask_clear
);

    // Registered architectural-to-physical map, live slots and snapshots.
    logic [PW-1:0]    r_map       [ARCH_REGS];
    logic [CKPTS-1:0] r_live;
    logic [PW-1:0]    r_snap_map  [CKPTS][ARCH_REGS];
    logic [CKPTS-1:0] r_snap_mask [CKPTS];

    // Next-state values produced by the rename walk.
    logic [PW-1:0]    w_map       [ARCH_REGS];
    logic [ARCH_REGS-1:0] w_fwd;
    logic [PW-1:0]    w_snap_map  [CKPTS][ARCH_REGS];
    logic [CKPTS-1:0] w_snap_mask [CKPTS];
    logic [CKPTS-1:0] w_alloc;
    logic [CKPTS-1:0] w_clear;
    resolve_kind_e    w_res_kind;

    // True when any same-cycle completion broadcast carries this tag.
    function automatic logic cdb_hit(input logic [PW-1:0] p,
                                     input logic [N-1:0] v,
                                     input logic [N-1:0][PW-1:0] t);
        logic hit;
        hit = 1'b0;
        for (int j = 0; j < N; j++) begin
            if (v[j] && (t[j] == p)) hit = 1'b1;
        end
        return hit;
    endfunction

    // Classify the resolve; a resolve to a dead slot does nothing at all.
    always_comb begin
        w_res_kind = RES_NONE;
        w_clear    = '0;
        if (resolve_valid && r_live[resolve_id]) begin
            w_res_kind = resolve_mispredict ? RES_MISPRED : RES_CORRECT;
        end
        if (w_res_kind == RES_CORRECT) w_clear[resolve_id] = 1'b1;
    end

    assign live_mask   = r_live;
    assign bmask_clear = reset ? '0 : w_clear;

    // Walk the lanes in order: rename, pick slots, and stop at the first
    // lane that cannot be accepted so the accepted lanes form a prefix.
    always_comb begin
        int               w_k;
        int               w_dests;
        int               w_brs;
        int               w_slot;
        logic             w_stop;
        logic             w_ok;
        logic             w_is_dest;
        logic             w_slot_ok;
        logic [PW-1:0]    w_new;
        logic [CKPTS-1:0] w_grp_br;
        logic [CKPTS-1:0] w_lane_mask;

        w_k         = 0;
        w_dests     = 0;
        w_brs       = 0;
        w_slot      = 0;
        w_ok        = 1'b0;
        w_is_dest   = 1'b0;
        w_slot_ok   = 1'b0;
        w_new       = '0;
        w_grp_br    = '0;
        w_lane_mask = '0;
        w_map       = r_map;
        w_fwd       = '0;
        w_alloc     = '0;
        for (int s = 0; s < CKPTS; s++) begin
            w_snap_mask[s] = r_snap_mask[s] & ~w_clear;
            for (int a = 0; a < ARCH_REGS; a++) w_snap_map[s][a] = r_snap_map[s][a];
        end
        out_src1       = '0;
        out_src2       = '0;
        out_dest       = '0;
        out_told       = '0;
        out_src1_ready = '0;
        out_src2_ready = '0;
        out_bmask      = '0;
        out_ckpt_valid = '0;
        out_ckpt_id    = '0;
        // Nothing dispatches in reset or while the map is being restored.
        w_stop = reset || (w_res_kind == RES_MISPRED);

        for (int i = 0; i < N; i++) begin
            // Sources see the registered map plus older lanes' renames.
            out_src1[i] = w_map[in_src1[i]];
            out_src2[i] = w_map[in_src2[i]];
            out_src1_ready[i] = !w_fwd[in_src1[i]] &&
                (!in_rs1_used[i] || (out_src1[i] == '0) || complete_list[out_src1[i]] ||
                 cdb_hit(out_src1[i], cdb_valid, cdb_tag));
            out_src2_ready[i] = !w_fwd[in_src2[i]] &&
                (!in_rs2_used[i] || (out_src2[i] == '0) || complete_list[out_src2[i]] ||
                 cdb_hit(out_src2[i], cdb_valid, cdb_tag));

            // The k-th destination lane takes free_regs[k].
            w_is_dest = in_has_dest[i] && (in_dest[i] != '0);
            w_new     = '0;
            for (int j = 0; j < N; j++) begin
                if (j == w_dests) w_new = free_regs[j];
            end
            out_dest[i] = w_is_dest ? w_new : '0;
            out_told[i] = w_is_dest ? w_map[in_dest[i]] : '0;

            // Lowest slot that is neither live nor taken earlier this group.
            w_slot_ok = 1'b0;
            w_slot    = 0;
            for (int s = 0; s < CKPTS; s++) begin
                if (!w_slot_ok && !r_live[s] && !w_alloc[s]) begin
                    w_slot_ok = 1'b1;
                    w_slot    = s;
                end
            end
            w_lane_mask    = (r_live & ~w_clear) | w_grp_br;
            out_bmask[i]   = w_lane_mask;
            out_ckpt_id[i] = CW'(w_slot);

            w_ok = !w_stop &&
                   (i < int'(in_count)) && (i < int'(rob_spots)) && (i < int'(rs_spots)) &&
                   (!w_is_dest || (w_dests < int'(free_count))) &&
                   (!in_is_branch[i] || ((w_brs < BR_PER_CYCLE) && w_slot_ok));

            if (w_ok) begin
                w_k = w_k + 1;
                if (w_is_dest) begin
                    w_map[in_dest[i]] = w_new;
                    w_fwd[in_dest[i]] = 1'b1;
                    w_dests = w_dests + 1;
                end
                if (in_is_branch[i]) begin
                    out_ckpt_valid[i] = 1'b1;
                    w_brs = w_brs + 1;
                    for (int s = 0; s < CKPTS; s++) begin
                        if (s == w_slot) begin
                            w_alloc[s]     = 1'b1;
                            w_grp_br[s]    = 1'b1;
                            w_snap_mask[s] = w_lane_mask;
                            for (int a = 0; a < ARCH_REGS; a++) w_snap_map[s][a] = w_map[a];
                        end
                    end
                end
            end else begin
                w_stop = 1'b1;
            end
        end

        num_dispatched = SW'(w_k);
        num_regs_used  = SW'(w_dests);
    end

    // Commit renames and checkpoints, or restore on a live mispredict.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int a = 0; a < ARCH_REGS; a++) r_map[a] <= PW'(a);
            r_live <= '0;
            for (int s = 0; s < CKPTS; s++) begin
                r_snap_mask[s] <= '0;
                for (int a = 0; a < ARCH_REGS; a++) r_snap_map[s][a] <= '0;
            end
        end else if (w_res_kind == RES_MISPRED) begin
            for (int a = 0; a < ARCH_REGS; a++) r_map[a] <= r_snap_map[resolve_id][a];
            r_live <= r_snap_mask[resolve_id];
        end else begin
            for (int a = 0; a < ARCH_REGS; a++) r_map[a] <= w_map[a];
            r_live <= (r_live & ~w_clear) | w_alloc;
            for (int s = 0; s < CKPTS; s++) begin
                r_snap_mask[s] <= w_snap_mask[s];
                for (int a = 0; a < ARCH_REGS; a++) r_snap_map[s][a] <= w_snap_map[s][a];
            end
        end
    end

endmodule

// File: tb/tb_rename_ckpt_dispatch.sv
// Directed bench for rename_ckpt_dispatch with the default geometry
// (2 lanes, 32 arch regs, 64 pregs, 4 checkpoints, 1 branch per cycle).
// Inputs change just after the falling edge; outputs are sampled 1ns later.
module tb_rename_ckpt_dispatch;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic [1:0]       in_count;
    logic [1:0][4:0]  in_src1, in_src2, in_dest;
    logic [1:0]       in_rs1_used, in_rs2_used, in_has_dest, in_is_branch;
    logic [1:0]       rob_spots, rs_spots;
    logic [6:0]       free_count;
    logic [1:0][5:0]  free_regs;
    logic [63:0]      complete_list;
    logic [1:0]       cdb_valid;
    logic [1:0][5:0]  cdb_tag;
    logic             resolve_valid, resolve_mispredict;
    logic [1:0]       resolve_id;
    logic [1:0]       num_dispatched, num_regs_used;
    logic [1:0][5:0]  out_src1, out_src2, out_dest, out_told;
    logic [1:0]       out_src1_ready, out_src2_ready;
    logic [1:0][3:0]  out_bmask;
    logic [1:0]       out_ckpt_valid;
    logic [1:0][1:0]  out_ckpt_id;
    logic [3:0]       live_mask, bmask_clear;

    int n_cmp  = 0;
    int n_fail = 0;

    rename_ckpt_dispatch dut (
        .clock(clock), .reset(reset), .in_count(in_count),
        .in_src1(in_src1), .in_src2(in_src2), .in_dest(in_dest),
        .in_rs1_used(in_rs1_used), .in_rs2_used(in_rs2_used),
        .in_has_dest(in_has_dest), .in_is_branch(in_is_branch),
        .rob_spots(rob_spots), .rs_spots(rs_spots), .free_count(free_count),
        .free_regs(free_regs), .complete_list(complete_list),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
        .resolve_valid(resolve_valid), .resolve_mispredict(resolve_mispredict),
        .resolve_id(resolve_id), .num_dispatched(num_dispatched),
        .num_regs_used(num_regs_used), .out_src1(out_src1), .out_src2(out_src2),
        .out_dest(out_dest), .out_told(out_told),
        .out_src1_ready(out_src1_ready), .out_src2_ready(out_src2_ready),
        .out_bmask(out_bmask), .out_ckpt_valid(out_ckpt_valid),
        .out_ckpt_id(out_ckpt_id), .live_mask(live_mask), .bmask_clear(bmask_clear)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Quiet inputs: no lanes, plenty of downstream room, nothing resolving.
    task automatic idle();
        in_count = 2'd0;
        in_src1 = '0; in_src2 = '0; in_dest = '0;
        in_rs1_used = '0; in_rs2_used = '0; in_has_dest = '0; in_is_branch = '0;
        rob_spots = 2'd2; rs_spots = 2'd2; free_count = 7'd2;
        free_regs = '0; complete_list = '0; cdb_valid = '0; cdb_tag = '0;
        resolve_valid = 1'b0; resolve_mispredict = 1'b0; resolve_id = '0;
    endtask

    initial begin
        idle();
        // Reset cycle: nothing dispatches, nothing is cleared.
        @(negedge clock); idle(); in_count = 2'd2; resolve_valid = 1'b1;
        #1;
        check("rst_nd", num_dispatched, 0);
        check("rst_clr", bmask_clear, 0);

        // Plain sources, readiness from complete_list and cdb.
        @(negedge clock); reset = 1'b0; idle();
        in_count = 2'd2;
        in_src1[0] = 5'd1; in_src2[0] = 5'd2; in_rs1_used[0] = 1'b1; in_rs2_used[0] = 1'b1;
        in_src1[1] = 5'd3; in_rs1_used[1] = 1'b1;
        complete_list = 64'h2; cdb_valid = 2'b01; cdb_tag[0] = 6'd3;
        #1;
        check("s1_live", live_mask, 0);
        check("s1_nd", num_dispatched, 2);
        check("s1_src1_0", out_src1[0], 1);
        check("s1_rdy1_0", out_src1_ready[0], 1);
        check("s1_src2_0", out_src2[0], 2);
        check("s1_rdy2_0", out_src2_ready[0], 0);
        check("s1_src1_1", out_src1[1], 3);
        check("s1_rdy1_1", out_src1_ready[1], 1);
        check("s1_used", num_regs_used, 0);
        check("s1_ckv", out_ckpt_valid, 0);

        // Intra-group forwarding: r5->p40 then lane1 reads r5; r6->p41.
        @(negedge clock); idle();
        in_count = 2'd2; in_has_dest = 2'b11; in_dest[0] = 5'd5; in_dest[1] = 5'd6;
        in_src1[1] = 5'd5; in_rs1_used[1] = 1'b1;
        free_regs[0] = 6'd40; free_regs[1] = 6'd41; complete_list = '1;
        #1;
        check("s2_nd", num_dispatched, 2);
        check("s2_used", num_regs_used, 2);
        check("s2_dest0", out_dest[0], 40);
        check("s2_told0", out_told[0], 5);
        check("s2_src1_1", out_src1[1], 40);
        check("s2_rdy1_1", out_src1_ready[1], 0);
        check("s2_dest1", out_dest[1], 41);
        check("s2_told1", out_told[1], 6);

        // Committed map, r0 never renames, compacted free_regs use.
        @(negedge clock); idle();
        in_count = 2'd2; in_src1[0] = 5'd5; in_rs1_used[0] = 1'b1;
        in_has_dest = 2'b11; in_dest[0] = 5'd0; in_dest[1] = 5'd7;
        free_count = 7'd1; free_regs[0] = 6'd42; free_regs[1] = 6'd9;
        #1;
        check("s3_src1_0", out_src1[0], 40);
        check("s3_rdy1_0", out_src1_ready[0], 0);
        check("s3_dest0", out_dest[0], 0);
        check("s3_told0", out_told[0], 0);
        check("s3_nd", num_dispatched, 2);
        check("s3_used", num_regs_used, 1);
        check("s3_dest1", out_dest[1], 42);
        check("s3_told1", out_told[1], 7);

        // One free register for two destination lanes.
        @(negedge clock); idle();
        in_count = 2'd2; in_has_dest = 2'b11; in_dest[0] = 5'd8; in_dest[1] = 5'd9;
        free_count = 7'd1; free_regs[0] = 6'd43; free_regs[1] = 6'd44;
        #1;
        check("s4_nd", num_dispatched, 1);
        check("s4_used", num_regs_used, 1);
        check("s4_dest0", out_dest[0], 43);

        // ROB / RS space limits.
        @(negedge clock); idle();
        in_count = 2'd2; rob_spots = 2'd1;
        #1;
        check("s5_rob1", num_dispatched, 1);
        rob_spots = 2'd2; rs_spots = 2'd0;
        #1;
        check("s5_rs0", num_dispatched, 0);
        rs_spots = 2'd2; in_count = 2'd1;
        #1;
        check("s5_cnt1", num_dispatched, 1);

        // Branch in lane0 takes slot0; lane1 depends on it.
        @(negedge clock); idle();
        in_count = 2'd2; in_is_branch = 2'b01;
        #1;
        check("s6_nd", num_dispatched, 2);
        check("s6_ckv", out_ckpt_valid, 2'b01);
        check("s6_id0", out_ckpt_id[0], 0);
        check("s6_bm0", out_bmask[0], 4'b0000);
        check("s6_bm1", out_bmask[1], 4'b0001);

        // r5->p50 in lane0, branch in lane1 takes slot1 (child of slot0).
        @(negedge clock); idle();
        in_count = 2'd2; in_has_dest = 2'b01; in_dest[0] = 5'd5; free_regs[0] = 6'd50;
        in_is_branch = 2'b10;
        #1;
        check("s7_live", live_mask, 4'b0001);
        check("s7_nd", num_dispatched, 2);
        check("s7_ckv", out_ckpt_valid, 2'b10);
        check("s7_id1", out_ckpt_id[1], 1);
        check("s7_bm0", out_bmask[0], 4'b0001);
        check("s7_bm1", out_bmask[1], 4'b0001);
        check("s7_dest0", out_dest[0], 50);

        // Two branches, one checkpoint per cycle: group stops at lane1.
        @(negedge clock); idle();
        in_count = 2'd2; in_is_branch = 2'b11; in_has_dest = 2'b01;
        in_dest[0] = 5'd5; free_regs[0] = 6'd51;
        #1;
        check("s8_nd", num_dispatched, 1);
        check("s8_ckv", out_ckpt_valid, 2'b01);
        check("s8_id0", out_ckpt_id[0], 2);
        check("s8_bm0", out_bmask[0], 4'b0011);

        // r6->p52 then a branch taking the last slot.
        @(negedge clock); idle();
        in_count = 2'd2; in_is_branch = 2'b10; in_has_dest = 2'b01;
        in_dest[0] = 5'd6; free_regs[0] = 6'd52;
        #1;
        check("s9_nd", num_dispatched, 2);
        check("s9_ckv", out_ckpt_valid, 2'b10);
        check("s9_id1", out_ckpt_id[1], 3);
        check("s9_bm1", out_bmask[1], 4'b0111);

        // All slots live: a branch cannot dispatch.
        @(negedge clock); idle();
        in_count = 2'd2; in_is_branch = 2'b10; in_src1[0] = 5'd5;
        #1;
        check("s10_live", live_mask, 4'b1111);
        check("s10_src1_0", out_src1[0], 51);
        check("s10_nd", num_dispatched, 1);
        check("s10_ckv", out_ckpt_valid, 0);
        in_is_branch = 2'b01;
        #1;
        check("s10_nd_b0", num_dispatched, 0);

        // Mispredict slot1: no dispatch this cycle.
        @(negedge clock); idle();
        in_count = 2'd2; in_has_dest = 2'b01; in_dest[0] = 5'd9; free_regs[0] = 6'd60;
        resolve_valid = 1'b1; resolve_mispredict = 1'b1; resolve_id = 2'd1;
        #1;
        check("s11_nd", num_dispatched, 0);
        check("s11_clr", bmask_clear, 0);
        check("s11_ckv", out_ckpt_valid, 0);

        // Map and live mask restored to slot1's snapshot.
        @(negedge clock); idle();
        in_src1[0] = 5'd5; in_src2[0] = 5'd6; in_src1[1] = 5'd9;
        #1;
        check("s12_live", live_mask, 4'b0001);
        check("s12_r5", out_src1[0], 50);
        check("s12_r6", out_src2[0], 41);
        check("s12_r9", out_src1[1], 9);

        // Mispredict slot0.
        @(negedge clock); idle();
        in_count = 2'd2;
        resolve_valid = 1'b1; resolve_mispredict = 1'b1; resolve_id = 2'd0;
        #1;
        check("s13_nd", num_dispatched, 0);

        @(negedge clock); idle();
        in_src1[0] = 5'd5; in_src2[0] = 5'd8;
        #1;
        check("s14_live", live_mask, 0);
        check("s14_r5", out_src1[0], 40);
        check("s14_r8", out_src2[0], 43);

        // Allocate slot0 again.
        @(negedge clock); idle();
        in_count = 2'd1; in_is_branch = 2'b01;
        #1;
        check("s15_id0", out_ckpt_id[0], 0);
        check("s15_ckv", out_ckpt_valid, 2'b01);

        // Correct resolve of slot0 alongside a branch dispatch.
        @(negedge clock); idle();
        in_count = 2'd2; in_is_branch = 2'b10;
        resolve_valid = 1'b1; resolve_id = 2'd0;
        #1;
        check("s16_clr", bmask_clear, 4'b0001);
        check("s16_nd", num_dispatched, 2);
        check("s16_bm0", out_bmask[0], 0);
        check("s16_bm1", out_bmask[1], 0);
        check("s16_ckv", out_ckpt_valid, 2'b10);
        check("s16_id1", out_ckpt_id[1], 1);

        // Slot0 reusable now; mispredict to a dead slot is ignored.
        @(negedge clock); idle();
        in_count = 2'd2; in_is_branch = 2'b01;
        resolve_valid = 1'b1; resolve_mispredict = 1'b1; resolve_id = 2'd3;
        #1;
        check("s17_live", live_mask, 4'b0010);
        check("s17_nd", num_dispatched, 2);
        check("s17_clr", bmask_clear, 0);
        check("s17_ckv", out_ckpt_valid, 2'b01);
        check("s17_id0", out_ckpt_id[0], 0);
        check("s17_bm0", out_bmask[0], 4'b0010);
        check("s17_bm1", out_bmask[1], 4'b0011);

        // Correct resolve to a dead slot is ignored.
        @(negedge clock); idle();
        resolve_valid = 1'b1; resolve_id = 2'd2;
        #1;
        check("s18_live", live_mask, 4'b0011);
        check("s18_clr", bmask_clear, 0);

        @(negedge clock); idle();
        #1;
        check("s19_live", live_mask, 4'b0011);

        // Reset mid-operation drops every checkpoint and the renames.
        @(negedge clock); idle(); reset = 1'b1; in_count = 2'd2;
        #1;
        check("s20_nd", num_dispatched, 0);

        @(negedge clock); reset = 1'b0; idle();
        in_src1[0] = 5'd5;
        #1;
        check("s21_live", live_mask, 0);
        check("s21_r5", out_src1[0], 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
